// File: rtl/uart_rx_frame_pkg.sv
// Shared UART framing definitions: FSM state encoding, data width and baud-count derivation,
// so the receiver and transmitter derive identical bit timing.
package uart_rx_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async serial pin plus a third flop for falling-edge detect.
// All flops reset to the idle-line level so a reset never fabricates a start edge.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,   // synchronous, active-low
  input  logic i_rx,
  output logic o_s2,
  output logic o_fe
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_s2 = r_s2;
  assign o_fe = r_s3 & ~r_s2;

endmodule

// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver: centre-samples each bit with an internal baud counter and presents the
// last good byte on rx_data, with rx_intr framing the reception for the downstream transmitter.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_intr,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int BIT_CNT  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CNT_W    = $clog2(BIT_CNT);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CNT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic w_s2;
  logic w_fe;

  uart_rx_sync u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_rx  (uart_rx),
    .o_s2  (w_s2),
    .o_fe  (w_fe)
  );

  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shreg;
  logic [7:0]       r_rx_data;
  logic             r_rx_intr;
  logic             r_rx_valid;
  logic             r_frame_err;

  logic w_cnt_clr;
  logic w_shift;
  logic w_bit_clr;
  logic w_done_ok;
  logic w_done_err;

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_bit_clr   = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fe) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_END) begin
          if (w_s2) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_bit_clr   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_END) begin
          w_shift = 1'b1;
          if (r_bit_idx == LAST_BIT) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_END) begin
          w_state_nxt = S_IDLE;
          w_done_ok   = w_s2;
          w_done_err  = ~w_s2;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Counter restarts on every state change and at each data-bit sample.
    w_cnt_clr = (w_state_nxt != r_state) | w_shift | (r_state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_rx_data   <= 8'h00;
      r_rx_intr   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_bit_clr)    r_bit_idx <= '0;
      else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_done_ok) r_rx_data <= r_shreg;
      // rx_intr falls on the same edge that raises rx_valid / frame_err, or on a glitch reject.
      r_rx_intr   <= (w_state_nxt != S_IDLE);
      r_rx_valid  <= w_done_ok;
      r_frame_err <= w_done_err;
    end
  end

  // Assembly register never reaches rx_data except on a good stop bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_shift) r_shreg <= {w_s2, r_shreg[7:1]};
  end

  assign rx_data   = r_rx_data;
  assign rx_intr   = r_rx_intr;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit: good frames, back-to-back frames,
// start glitch, bad stop bit, mid-frame reset and a long break.
module tb_uart_rx_frame;

  localparam int BITC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_intr;
  logic       rx_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_frame #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_intr   (rx_intr),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         intr_run = 0;
  int         intr_len = 0;
  logic [7:0] data_log [0:31];
  int         valid_cyc [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      data_log[n_valid[4:0]]  <= rx_data;
      valid_cyc[n_valid[4:0]] <= cyc;
      n_valid                 <= n_valid + 1;
    end
    if (frame_err) n_err <= n_err + 1;
    if (rx_valid && frame_err) n_both <= n_both + 1;
    if (rx_intr) begin
      intr_run <= intr_run + 1;
    end else if (intr_run != 0) begin
      intr_len <= intr_run;
      intr_run <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    wait_clks(BITC);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      wait_clks(BITC);
    end
    uart_rx = stop;
    wait_clks(BITC);
    uart_rx = 1'b1;
  endtask

  int v0, e0;

  initial begin
    rst     = 1'b0;
    uart_rx = 1'b1;
    wait_clks(4);
    #1;
    check_eq("rst_data",  {24'd0, rx_data}, 32'h00);
    check_eq("rst_intr",  {31'd0, rx_intr}, 32'd0);
    check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_ferr",  {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    wait_clks(4);

    // single good frame
    v0 = n_valid; e0 = n_err;
    send_frame(8'h55, 1'b1);
    wait_clks(2 * BITC);
    #1;
    check_eq("t1_valid_cnt", n_valid - v0, 32'd1);
    check_eq("t1_err_cnt",   n_err - e0,   32'd0);
    check_eq("t1_data",      {24'd0, rx_data}, 32'h55);
    check_eq("t1_intr_len_152", {31'd0, (intr_len >= 151 && intr_len <= 153)}, 32'd1);
    check_eq("t1_intr_low", {31'd0, rx_intr}, 32'd0);

    // back-to-back frames
    v0 = n_valid; e0 = n_err;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_clks(2 * BITC);
    #1;
    check_eq("t2_valid_cnt", n_valid - v0, 32'd2);
    check_eq("t2_data0",     {24'd0, data_log[v0[4:0]]}, 32'hA3);
    check_eq("t2_data1",     {24'd0, data_log[v0[4:0] + 5'd1]}, 32'h0F);
    check_eq("t2_gap",       valid_cyc[v0[4:0] + 5'd1] - valid_cyc[v0[4:0]], 32'd160);
    check_eq("t2_err_cnt",   n_err - e0, 32'd0);

    // 4-clock start glitch
    v0 = n_valid; e0 = n_err;
    intr_len = 0;
    uart_rx = 1'b0;
    wait_clks(4);
    uart_rx = 1'b1;
    wait_clks(2 * BITC);
    #1;
    check_eq("t3_intr_short", {31'd0, (intr_len >= 1 && intr_len < 10)}, 32'd1);
    check_eq("t3_valid_cnt",  n_valid - v0, 32'd0);
    check_eq("t3_err_cnt",    n_err - e0,   32'd0);
    check_eq("t3_data_hold",  {24'd0, rx_data}, 32'h0F);

    // bad stop bit, then recovery
    v0 = n_valid; e0 = n_err;
    send_frame(8'h3C, 1'b0);
    wait_clks(2 * BITC);
    #1;
    check_eq("t4_err_cnt",   n_err - e0,   32'd1);
    check_eq("t4_valid_cnt", n_valid - v0, 32'd0);
    check_eq("t4_data_hold", {24'd0, rx_data}, 32'h0F);
    v0 = n_valid;
    send_frame(8'h81, 1'b1);
    wait_clks(2 * BITC);
    #1;
    check_eq("t4_next_valid", n_valid - v0, 32'd1);
    check_eq("t4_next_data",  {24'd0, rx_data}, 32'h81);

    // reset during bit 4; bits 4..7 and stop are high so no new edge follows
    v0 = n_valid; e0 = n_err;
    uart_rx = 1'b0;
    wait_clks(BITC);
    for (int i = 0; i < 4; i++) wait_clks(BITC);
    uart_rx = 1'b1;
    wait_clks(BITC / 2);
    #1;
    check_eq("t5_intr_before", {31'd0, rx_intr}, 32'd1);
    rst = 1'b0;
    wait_clks(3);
    #1;
    check_eq("t5_rst_data",  {24'd0, rx_data}, 32'h00);
    check_eq("t5_rst_intr",  {31'd0, rx_intr}, 32'd0);
    check_eq("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("t5_rst_ferr",  {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    wait_clks(6 * BITC);
    #1;
    check_eq("t5_valid_cnt", n_valid - v0, 32'd0);
    check_eq("t5_err_cnt",   n_err - e0,   32'd0);
    check_eq("t5_intr_idle", {31'd0, rx_intr}, 32'd0);
    check_eq("t5_data_zero", {24'd0, rx_data}, 32'h00);

    // 40-bit break then good 0xFF
    v0 = n_valid; e0 = n_err;
    uart_rx = 1'b0;
    wait_clks(40 * BITC);
    uart_rx = 1'b1;
    wait_clks(2 * BITC);
    #1;
    check_eq("t6_err_once",  n_err - e0,   32'd1);
    check_eq("t6_valid_cnt", n_valid - v0, 32'd0);
    v0 = n_valid;
    send_frame(8'hFF, 1'b1);
    wait_clks(2 * BITC);
    #1;
    check_eq("t6_ff_valid", n_valid - v0, 32'd1);
    check_eq("t6_ff_data",  {24'd0, rx_data}, 32'hFF);

    check_eq("never_both", n_both, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
